// File: rtl/iot_stream_if.sv
// iot_stream_if: upstream record handshake, engine byte stream and result capture signals of iot_stream_tx.
interface iot_stream_if;
   logic         rec_valid;
   logic [127:0] rec_data;
   logic         rec_ready;
   logic         in_en;
   logic [7:0]   iot_in;
   logic [2:0]   fn_sel;
   logic         busy;
   logic         valid;
   logic [127:0] iot_out;
   logic         res_valid;
   logic [127:0] res_data;
   modport master (
      input  rec_valid, rec_data, busy, valid, iot_out,
      output rec_ready, in_en, iot_in, fn_sel, res_valid, res_data
   );
   modport slave (
      output rec_valid, rec_data, busy, valid, iot_out,
      input  rec_ready, in_en, iot_in, fn_sel, res_valid, res_data
   );
endinterface

// File: rtl/iot_stream_tx.sv
// iot_stream_tx: serializes 128-bit records MSB byte first onto the engine byte stream,
// one round of RECORDS_PER_ROUND records per start, and re-presents engine results upstream.
module iot_stream_tx #(
   parameter int RECORDS_PER_ROUND = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [2:0]   fn_cfg,
   output logic         round_done,
   output logic         proto_err,
   iot_stream_if.master io
);
   typedef enum logic [1:0] {IDLE, FILL, SEND, DONE} state_t;
   localparam logic [3:0] LAST = 4'(RECORDS_PER_ROUND);
   state_t       state, state_nx;
   logic [127:0] buf_q, shift_q;
   logic         buf_full;
   logic [3:0]   rec_cnt, byte_cnt;
   logic         start_ok, accept, last_byte, launch, all_in;
   logic         in_en_nx, done_nx;

   assign start_ok     = (state == IDLE) && start && (fn_cfg != 3'd0);
   assign io.rec_ready = ((state == FILL) || (state == SEND)) && !buf_full && (rec_cnt < LAST);
   assign accept       = io.rec_valid && io.rec_ready;
   assign last_byte    = (state == SEND) && (byte_cnt == 4'd15);
   // busy only gates a launch, which happens solely between records
   assign launch       = buf_full && !io.busy && ((state == FILL) || last_byte);
   assign all_in       = (rec_cnt == LAST) && !buf_full;
   assign io.iot_in    = shift_q[127:120];

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    state_nx = start_ok ? FILL : IDLE;
         FILL:    state_nx = launch ? SEND : FILL;
         SEND:    state_nx = (!last_byte || launch) ? SEND : (all_in ? DONE : FILL);
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      in_en_nx = (state_nx == SEND);
      done_nx  = (state_nx == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_q        <= '0;
         buf_full     <= 1'b0;
         shift_q      <= '0;
         rec_cnt      <= '0;
         byte_cnt     <= '0;
         io.in_en     <= 1'b0;
         io.fn_sel    <= '0;
         round_done   <= 1'b0;
         proto_err    <= 1'b0;
         io.res_valid <= 1'b0;
         io.res_data  <= '0;
      end else begin
         if (accept) buf_q <= io.rec_data;
         buf_full     <= accept || (buf_full && !launch);
         shift_q      <= launch ? buf_q : ((state == SEND) ? shift_q << 8 : shift_q);
         rec_cnt      <= start_ok ? 4'd0 : rec_cnt + 4'(accept);
         byte_cnt     <= launch ? 4'd0 : ((state == SEND) ? byte_cnt + 4'd1 : byte_cnt);
         io.in_en     <= in_en_nx;
         io.fn_sel    <= start_ok ? fn_cfg : io.fn_sel;
         round_done   <= done_nx;
         proto_err    <= start_ok ? 1'b0 : (proto_err || ((state == SEND) && (byte_cnt != 4'd0) && io.busy));
         io.res_valid <= io.valid;
         if (io.valid) io.res_data <= io.iot_out;
      end
   end
endmodule
